// File: rtl/digit_scan_mux.sv
// digit_scan_mux
//   Time-multiplexes four hex digits onto one shared 7-segment decoder nibble.
//   Each digit gets a slot of PRESCALE lit cycles followed by BLANK all-off
//   cycles. New data is written to a pending buffer and only copied to the
//   displayed (active) buffer at a frame boundary, so a frame never tears.
//
// Parameters
//   PRESCALE    lit (SHOW) cycles per digit slot, 1..65535
//   BLANK       all-off cycles after each SHOW period, 0..255
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din[15:0]   four hex digits, din[3:0] is digit0 (rightmost)
//   load        capture din at this edge
//   lz_en       leading-zero suppression enable (combinational effect)
//   w,x,y,z     digit nibble for the segment decoder, w is the MSB
//   an[3:0]     active-low digit enables
//   frame_done  one-cycle pulse on the first cycle of each new frame
module digit_scan_mux #(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        load,
  input  logic        lz_en,
  output logic        w,
  output logic        x,
  output logic        y,
  output logic        z,
  output logic [3:0]  an,
  output logic        frame_done
);

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] BLK_LAST = (BLANK > 0) ? 16'(BLANK - 1) : 16'd0;
  localparam bit          NO_BLANK = (BLANK == 0);

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic [15:0] active;
  logic [15:0] pending;
  logic        valid;

  logic        slot_end;
  logic        transfer;
  logic [3:0]  sup;
  logic [3:0]  cur_digit;
  logic [3:0]  nib;

  // A slot ends on the last BLANK cycle, or on the last SHOW cycle when the
  // blank period is configured away. Leaving digit3 is the frame boundary.
  assign slot_end = (state == ST_SHOW  && cnt == PRE_LAST && NO_BLANK) ||
                    (state == ST_BLANK && cnt == BLK_LAST);
  assign transfer = slot_end && (idx == 2'd3);

  // Scan FSM plus the double-buffered digit storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_SHOW;
      idx        <= 2'd0;
      cnt        <= 16'd0;
      active     <= 16'd0;
      pending    <= 16'd0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= transfer;

      case (state)
        ST_SHOW: begin
          if (cnt == PRE_LAST) begin
            cnt <= 16'd0;
            if (NO_BLANK) begin
              idx <= idx + 2'd1;
            end else begin
              state <= ST_BLANK;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLK_LAST) begin
            state <= ST_SHOW;
            idx   <= idx + 2'd1;
            cnt   <= 16'd0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_SHOW;
          cnt   <= 16'd0;
        end
      endcase

      // A load that coincides with the frame boundary bypasses pending so
      // the freshest value is what the new frame shows.
      if (load) begin
        pending <= din;
      end
      if (transfer) begin
        if (load) begin
          active <= din;
        end else if (valid) begin
          active <= pending;
        end
        valid <= 1'b0;
      end else if (load) begin
        valid <= 1'b1;
      end
    end
  end

  // Suppression chains downward: a digit is blank only if it and every digit
  // above it are zero. Digit0 is always shown.
  assign sup[3] = lz_en && (active[15:12] == 4'd0);
  assign sup[2] = sup[3] && (active[11:8] == 4'd0);
  assign sup[1] = sup[2] && (active[7:4] == 4'd0);
  assign sup[0] = 1'b0;

  assign cur_digit = active[{idx, 2'b00} +: 4];

  // Moore decode of the registered scan position.
  always_comb begin
    an  = 4'b1111;
    nib = 4'b0000;
    if (state == ST_SHOW && !sup[idx]) begin
      an[idx] = 1'b0;
      nib     = cur_digit;
    end
  end

  assign {w, x, y, z} = nib;

endmodule

// File: tb/tb_digit_scan_mux.sv
// tb_digit_scan_mux
//   Self-checking bench for digit_scan_mux. Two instances share the inputs:
//   dut uses the default timing (PRESCALE=4, BLANK=1) and dut_nb removes the
//   blank period (BLANK=0). A frame-arithmetic reference model predicts every
//   output of both instances on every cycle; a constant table and a few
//   hand-written sequences pin down the documented scenarios.
module tb_digit_scan_mux;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;

  logic        w, x, y, z, frame_done;
  logic [3:0]  an;
  logic        w_nb, x_nb, y_nb, z_nb, frame_done_nb;
  logic [3:0]  an_nb;

  digit_scan_mux #(.PRESCALE(4), .BLANK(1)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load), .lz_en(lz_en),
    .w(w), .x(x), .y(y), .z(z), .an(an), .frame_done(frame_done)
  );

  digit_scan_mux #(.PRESCALE(4), .BLANK(0)) dut_nb (
    .clk(clk), .rst(rst), .din(din), .load(load), .lz_en(lz_en),
    .w(w_nb), .x(x_nb), .y(y_nb), .z(z_nb), .an(an_nb), .frame_done(frame_done_nb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time since reset plus the two data buffers. Scan
  // position is derived purely from the cycle index by division.
  int          m_t[2];
  logic [15:0] m_act[2];
  logic [15:0] m_pend[2];
  bit          m_pv[2];
  int          blank_of[2] = '{1, 0};

  function automatic int slot_len(int k);
    return P + blank_of[k];
  endfunction

  function automatic logic [3:0] exp_an(int k);
    int slot = (m_t[k] / slot_len(k)) % 4;
    int pos  = m_t[k] % slot_len(k);
    if (pos >= P) return 4'b1111;
    if (slot != 0 && lz_en && ((m_act[k] >> (4 * slot)) == 16'd0)) return 4'b1111;
    return ~(4'b0001 << slot);
  endfunction

  function automatic logic [3:0] exp_nib(int k);
    int slot = (m_t[k] / slot_len(k)) % 4;
    int pos  = m_t[k] % slot_len(k);
    if (pos >= P) return 4'b0000;
    if (slot != 0 && lz_en && ((m_act[k] >> (4 * slot)) == 16'd0)) return 4'b0000;
    return 4'((m_act[k] >> (4 * slot)) & 16'h000F);
  endfunction

  function automatic logic exp_fd(int k);
    return (m_t[k] != 0) && ((m_t[k] % (4 * slot_len(k))) == 0);
  endfunction

  task automatic modelStep(int k, logic r, logic l, logic [15:0] d);
    bit boundary;
    if (r) begin
      m_t[k] = 0; m_act[k] = 16'd0; m_pend[k] = 16'd0; m_pv[k] = 1'b0;
    end else begin
      boundary = ((m_t[k] + 1) % (4 * slot_len(k))) == 0;
      if (boundary) begin
        if (l) m_act[k] = d;
        else if (m_pv[k]) m_act[k] = m_pend[k];
        m_pv[k] = 1'b0;
        if (l) m_pend[k] = d;
      end else if (l) begin
        m_pend[k] = d;
        m_pv[k]   = 1'b1;
      end
      m_t[k] = m_t[k] + 1;
    end
  endtask

  task automatic check(string name, logic [15:0] actual, logic [15:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s at t=%0d: got %h expected %h", name, m_t[0], actual, expected);
  endtask

  task automatic checkOutput();
    check("an",        {12'd0, an},                 {12'd0, exp_an(0)});
    check("wxyz",      {12'd0, w, x, y, z},         {12'd0, exp_nib(0)});
    check("frame_done",{15'd0, frame_done},         {15'd0, exp_fd(0)});
    check("an_onehot", 16'($countones(~an) <= 1),   16'd1);
    check("nb_an",     {12'd0, an_nb},              {12'd0, exp_an(1)});
    check("nb_wxyz",   {12'd0, w_nb, x_nb, y_nb, z_nb}, {12'd0, exp_nib(1)});
    check("nb_frame_done", {15'd0, frame_done_nb},  {15'd0, exp_fd(1)});
    check("nb_an_onehot", 16'($countones(~an_nb) <= 1), 16'd1);
  endtask

  // One clock edge with the given inputs, model update, then full compare.
  task automatic applyStimulus(logic r, logic l, logic [15:0] d);
    rst = r; load = l; din = d;
    @(posedge clk);
    modelStep(0, r, l, d);
    modelStep(1, r, l, d);
    #1;
    rst = 1'b0; load = 1'b0;
    checkOutput();
  endtask

  // Idle until the default instance reaches the given cycle within its frame.
  task automatic runUntil(int target);
    int guard = 0;
    while ((m_t[0] % 20) != target && guard < 100) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      guard++;
    end
    if ((m_t[0] % 20) != target) begin
      n_checks++;
      $display("[TB] FAIL run_until: got frame pos %0d expected %0d", m_t[0] % 20, target);
    end
  endtask

  task automatic checkConst(string name, logic [3:0] e_an, logic [3:0] e_nib, logic e_fd);
    check({name, "_an"},   {12'd0, an},         {12'd0, e_an});
    check({name, "_wxyz"}, {12'd0, w, x, y, z}, {12'd0, e_nib});
    check({name, "_fd"},   {15'd0, frame_done}, {15'd0, e_fd});
  endtask

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] din;
    logic        lz;
    int          n;
    logic [3:0]  an;
    logic [3:0]  nib;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(logic r, logic l, logic [15:0] d, logic lz, int n,
                        logic [3:0] e_an, logic [3:0] e_nib, logic e_fd);
    vec_t v;
    v.rst = r; v.load = l; v.din = d; v.lz = lz; v.n = n;
    v.an = e_an; v.nib = e_nib; v.fd = e_fd;
    vecs.push_back(v);
  endtask

  initial begin
    int blanks;
    int last_fd;
    int pulses;
    int seen_nine;

    // Reset, load 1234 in the first frame, then two full frames of scanning.
    addVec(1, 0, 16'h0000, 0, 1, 4'b1110, 4'h0, 0);
    addVec(0, 1, 16'h1234, 0, 1, 4'b1110, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 2, 4'b1110, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 4, 4'b1101, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 4, 4'b1011, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 4, 4'b0111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1110, 4'h4, 1);
    addVec(0, 0, 16'h0000, 0, 3, 4'b1110, 4'h4, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 4, 4'b1101, 4'h3, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 4, 4'b1011, 4'h2, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 4, 4'b0111, 4'h1, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1111, 4'h0, 0);
    addVec(0, 0, 16'h0000, 0, 1, 4'b1110, 4'h4, 1);

    for (int k = 0; k < 2; k++) begin
      m_t[k] = 0; m_act[k] = 16'd0; m_pend[k] = 16'd0; m_pv[k] = 1'b0;
    end

    $display("[TB] table: reset and load scan");
    foreach (vecs[i]) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        lz_en = vecs[i].lz;
        applyStimulus(vecs[i].rst, vecs[i].load, vecs[i].din);
        checkConst($sformatf("vec%0d", i), vecs[i].an, vecs[i].nib, vecs[i].fd);
      end
    end

    $display("[TB] tear-free update");
    runUntil(10);
    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    checkConst("tear_d2_old", 4'b1011, 4'h2, 0);
    runUntil(15);
    checkConst("tear_d3_old", 4'b0111, 4'h1, 0);
    runUntil(0);
    checkConst("tear_d0_new", 4'b1110, 4'hF, 1);
    runUntil(15);
    checkConst("tear_d3_new", 4'b0111, 4'hF, 0);
    runUntil(19);
    applyStimulus(1'b0, 1'b1, 16'hA5C3);
    checkConst("direct_d0", 4'b1110, 4'h3, 1);
    runUntil(5);
    checkConst("direct_d1", 4'b1101, 4'hC, 0);

    $display("[TB] leading zeros");
    applyStimulus(1'b0, 1'b1, 16'h0070);
    lz_en = 1'b1;
    runUntil(0);
    checkConst("lz_d0", 4'b1110, 4'h0, 1);
    runUntil(5);
    checkConst("lz_d1", 4'b1101, 4'h7, 0);
    runUntil(10);
    checkConst("lz_d2", 4'b1111, 4'h0, 0);
    runUntil(15);
    checkConst("lz_d3", 4'b1111, 4'h0, 0);
    lz_en = 1'b0;
    #1;
    checkConst("lz_off_d3", 4'b0111, 4'h0, 0);
    checkOutput();
    runUntil(10);
    checkConst("lz_off_d2", 4'b1011, 4'h0, 0);

    $display("[TB] no-blank timing");
    blanks  = 0;
    last_fd = -1;
    pulses  = 0;
    for (int i = 0; i < 48; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      if (an_nb == 4'b1111) blanks++;
      if (frame_done_nb) begin
        if (last_fd >= 0) check("nb_fd_period", 16'(i - last_fd), 16'd16);
        last_fd = i;
        pulses++;
      end
    end
    check("nb_never_blank", 16'(blanks), 16'd0);
    check("nb_fd_pulses", 16'(pulses), 16'd3);

    $display("[TB] mid-frame reset");
    runUntil(1);
    applyStimulus(1'b0, 1'b1, 16'h9999);
    runUntil(11);
    applyStimulus(1'b1, 1'b0, 16'h0000);
    checkConst("rst_mid", 4'b1110, 4'h0, 0);
    pulses    = 0;
    seen_nine = 0;
    for (int i = 0; i < 19; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000);
      if (frame_done) pulses++;
      if ({w, x, y, z} == 4'h9) seen_nine++;
    end
    check("rst_no_fd", 16'(pulses), 16'd0);
    check("rst_no_pending", 16'(seen_nine), 16'd0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    checkConst("rst_first_frame", 4'b1110, 4'h0, 1);

    $display("[TB] randomized run");
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 24) == 0) lz_en = ~lz_en;
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 5) == 0,
                    16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom));
      if ($urandom_range(0, 6) == 0) begin
        lz_en = ~lz_en;
        #1;
        checkOutput();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
